// File: rtl/ex_stage_md.sv
// ex_stage_md: RV32I execute stage with an iterative multiply/divide unit and
// the EX/MEM pipeline register.
//
// Optional feature macro: M_EXT_EN
//   defined   - multi-cycle MUL/DIV/DIVU/REM/REMU unit with IDLE/CALC/DONE FSM;
//               ex_busy stalls the front of the pipeline while it runs.
//   undefined - no FSM; ex_busy is tied to 0 and M-extension encodings give
//               alu_out = dataA in a single cycle.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   id_ex_*               decoded instruction, operands and control from ID/EX
//   forward_a/forward_b   00/11 = ID/EX, 01 = wb_data, 10 = ex_mem_alu_out
//   wb_data               writeback forwarding source
//   alu_out               combinational execute result
//   ex_busy               combinational stall request (hold IF/ID, ID/EX, PC)
//   ex_mem_*              registered EX/MEM outputs
module ex_stage_md #(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            id_ex_valid,
    input  logic            id_ex_mem_to_reg,
    input  logic            id_ex_reg_write,
    input  logic            id_ex_mem_write,
    input  logic            id_ex_mem_read,
    input  logic            id_ex_alu_src,
    input  logic [1:0]      id_ex_alu_op,
    input  logic [2:0]      id_ex_funct3,
    input  logic            id_ex_funct7b5,
    input  logic            id_ex_funct7b0,
    input  logic [XLEN-1:0] id_ex_data1,
    input  logic [XLEN-1:0] id_ex_data2,
    input  logic [XLEN-1:0] id_ex_imm,
    input  logic [4:0]      id_ex_rd,
    input  logic [1:0]      forward_a,
    input  logic [1:0]      forward_b,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] alu_out,
    output logic            ex_busy,
    output logic [XLEN-1:0] ex_mem_alu_out,
    output logic [XLEN-1:0] ex_mem_dataB,
    output logic            ex_mem_mem_to_reg,
    output logic            ex_mem_reg_write,
    output logic            ex_mem_mem_write,
    output logic            ex_mem_mem_read,
    output logic [4:0]      ex_mem_rd
);

    // ------------------------------------------------------------------
    // EX/MEM register state
    // ------------------------------------------------------------------
    logic [XLEN-1:0] ex_mem_alu_out_q, ex_mem_alu_out_d;
    logic [XLEN-1:0] ex_mem_data_b_q, ex_mem_data_b_d;
    logic            ex_mem_mem_to_reg_q, ex_mem_mem_to_reg_d;
    logic            ex_mem_reg_write_q, ex_mem_reg_write_d;
    logic            ex_mem_mem_write_q, ex_mem_mem_write_d;
    logic            ex_mem_mem_read_q, ex_mem_mem_read_d;
    logic [4:0]      ex_mem_rd_q, ex_mem_rd_d;

    // ------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------
    logic [XLEN-1:0] data_a, data_b, op_b;

    always_comb begin
        case (forward_a)
            2'b01:   data_a = wb_data;
            2'b10:   data_a = ex_mem_alu_out_q;
            default: data_a = id_ex_data1;
        endcase
        case (forward_b)
            2'b01:   data_b = wb_data;
            2'b10:   data_b = ex_mem_alu_out_q;
            default: data_b = id_ex_data2;
        endcase
        op_b = id_ex_alu_src ? id_ex_imm : data_b;
    end

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] sra_res;
    logic [3:0]      code;
    logic            md_op;   // M-extension encoding (alu_op 10, bit 25 set)
    logic            md_fn;   // encodings actually executed by the MDU
    logic [XLEN-1:0] alu_res;

    assign shamt   = op_b[SHW-1:0];
    assign sra_res = $unsigned($signed(data_a) >>> shamt);
    assign md_op   = (id_ex_alu_op == 2'b10) && id_ex_funct7b0;
    assign md_fn   = md_op && (id_ex_funct3 == 3'b000 || id_ex_funct3[2]);

    always_comb begin
        alu_res = data_a;
        code    = {id_ex_funct7b5, id_ex_funct3};
        // I-type only has a funct7 field for the shift-right encodings
        if (id_ex_alu_op == 2'b11 && id_ex_funct3 != 3'b101)
            code = {1'b0, id_ex_funct3};
        case (id_ex_alu_op)
            2'b00: alu_res = data_a + op_b;
            2'b01: alu_res = data_a - op_b;
            default: begin
                if (!md_op) begin
                    case (code)
                        4'b0000: alu_res = data_a + op_b;
                        4'b1000: alu_res = data_a - op_b;
                        4'b0001: alu_res = data_a << shamt;
                        4'b0010: alu_res = {{(XLEN-1){1'b0}}, $signed(data_a) < $signed(op_b)};
                        4'b0011: alu_res = {{(XLEN-1){1'b0}}, data_a < op_b};
                        4'b0100: alu_res = data_a ^ op_b;
                        4'b0101: alu_res = data_a >> shamt;
                        4'b1101: alu_res = sra_res;
                        4'b0110: alu_res = data_a | op_b;
                        4'b0111: alu_res = data_a & op_b;
                        default: alu_res = data_a;
                    endcase
                end
`ifdef M_EXT_EN
                // funct3 001/010/011 complete as 0 in a single cycle
                else if (!md_fn) begin
                    alu_res = '0;
                end
`endif
            end
        endcase
    end

`ifdef M_EXT_EN
    // ------------------------------------------------------------------
    // Iterative multiply/divide unit
    // a_q:   multiplicand (MUL) or dividend magnitude shifting into quotient
    // b_q:   multiplier (MUL) or divisor magnitude
    // acc_q: product accumulator (MUL) or partial remainder (DIV/REM)
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [2:0]      op3_q, op3_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN:0]   acc_q, acc_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            spec_q, spec_d;
    logic [XLEN-1:0] spec_res_q, spec_res_d;

    logic            start, signed_div, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, md_result;
    logic [XLEN:0]   shifted, diff;
    logic [XLEN-1:0] min_neg;

    assign min_neg    = {1'b1, {(XLEN-1){1'b0}}};
    // reset_n gate keeps ex_busy low while reset is held with an M op presented
    assign start      = (state_q == IDLE) && id_ex_valid && md_fn && reset_n;
    assign signed_div = id_ex_funct3[2] && !id_ex_funct3[0];
    assign div_zero   = id_ex_funct3[2] && (data_b == '0);
    assign div_ovf    = signed_div && (data_a == min_neg) && (data_b == '1);
    assign mag_a      = (signed_div && data_a[XLEN-1]) ? -data_a : data_a;
    assign mag_b      = (signed_div && data_b[XLEN-1]) ? -data_b : data_b;
    assign shifted    = {acc_q[XLEN-1:0], a_q[XLEN-1]};
    assign diff       = shifted - {1'b0, b_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op3_d      = op3_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op3_d = id_ex_funct3;
                    if (div_zero || div_ovf) begin
                        state_d = DONE;
                        spec_d  = 1'b1;
                        if (div_zero)
                            spec_res_d = id_ex_funct3[1] ? data_a : '1;
                        else
                            spec_res_d = id_ex_funct3[1] ? '0 : data_a;
                    end else begin
                        state_d   = CALC;
                        spec_d    = 1'b0;
                        cnt_d     = SHW'(XLEN-1);
                        acc_d     = '0;
                        a_d       = id_ex_funct3[2] ? mag_a : data_a;
                        b_d       = id_ex_funct3[2] ? mag_b : data_b;
                        neg_quo_d = signed_div && (data_a[XLEN-1] ^ data_b[XLEN-1]);
                        neg_rem_d = signed_div && data_a[XLEN-1];
                    end
                end
            end
            CALC: begin
                if (!op3_q[2]) begin
                    if (b_q[0]) acc_d = acc_q + {1'b0, a_q};
                    a_d = a_q << 1;
                    b_d = b_q >> 1;
                end else if (!diff[XLEN]) begin
                    // no borrow: the divisor fits, keep the difference
                    acc_d = diff;
                    a_d   = {a_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = shifted;
                    a_d   = {a_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (spec_q)
            md_result = spec_res_q;
        else if (!op3_q[2])
            md_result = acc_q[XLEN-1:0];
        else if (op3_q[1])
            md_result = neg_rem_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        else
            md_result = neg_quo_q ? -a_q : a_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op3_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op3_q      <= op3_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
        end
    end

    assign ex_busy = start || (state_q == CALC);
    always_comb begin
        alu_out = alu_res;
        if (state_q == DONE)
            alu_out = md_result;
        else if (md_fn)
            alu_out = '0;
    end
`else
    logic unused_md;
    assign unused_md = id_ex_valid & md_fn;
    assign ex_busy   = 1'b0;
    assign alu_out   = alu_res;
`endif

    // ------------------------------------------------------------------
    // EX/MEM register: bubble while stalled, result/data held
    // ------------------------------------------------------------------
    always_comb begin
        ex_mem_alu_out_d    = ex_mem_alu_out_q;
        ex_mem_data_b_d     = ex_mem_data_b_q;
        ex_mem_mem_to_reg_d = 1'b0;
        ex_mem_reg_write_d  = 1'b0;
        ex_mem_mem_write_d  = 1'b0;
        ex_mem_mem_read_d   = 1'b0;
        ex_mem_rd_d         = 5'd0;
        if (!ex_busy) begin
            ex_mem_alu_out_d    = alu_out;
            ex_mem_data_b_d     = data_b;
            ex_mem_mem_to_reg_d = id_ex_mem_to_reg;
            ex_mem_reg_write_d  = id_ex_reg_write;
            ex_mem_mem_write_d  = id_ex_mem_write;
            ex_mem_mem_read_d   = id_ex_mem_read;
            ex_mem_rd_d         = id_ex_rd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_mem_alu_out_q    <= '0;
            ex_mem_data_b_q     <= '0;
            ex_mem_mem_to_reg_q <= 1'b0;
            ex_mem_reg_write_q  <= 1'b0;
            ex_mem_mem_write_q  <= 1'b0;
            ex_mem_mem_read_q   <= 1'b0;
            ex_mem_rd_q         <= 5'd0;
        end else begin
            ex_mem_alu_out_q    <= ex_mem_alu_out_d;
            ex_mem_data_b_q     <= ex_mem_data_b_d;
            ex_mem_mem_to_reg_q <= ex_mem_mem_to_reg_d;
            ex_mem_reg_write_q  <= ex_mem_reg_write_d;
            ex_mem_mem_write_q  <= ex_mem_mem_write_d;
            ex_mem_mem_read_q   <= ex_mem_mem_read_d;
            ex_mem_rd_q         <= ex_mem_rd_d;
        end
    end

    assign ex_mem_alu_out    = ex_mem_alu_out_q;
    assign ex_mem_dataB      = ex_mem_data_b_q;
    assign ex_mem_mem_to_reg = ex_mem_mem_to_reg_q;
    assign ex_mem_reg_write  = ex_mem_reg_write_q;
    assign ex_mem_mem_write  = ex_mem_mem_write_q;
    assign ex_mem_mem_read   = ex_mem_mem_read_q;
    assign ex_mem_rd         = ex_mem_rd_q;

endmodule

// File: tb/tb_ex_stage_md.sv
// tb_ex_stage_md: directed-vector bench for ex_stage_md (XLEN = 32).
// Expectations for the multiply/divide unit follow the M_EXT_EN setting.
module tb_ex_stage_md;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        id_ex_valid, id_ex_mem_to_reg, id_ex_reg_write, id_ex_mem_write, id_ex_mem_read;
    logic        id_ex_alu_src;
    logic [1:0]  id_ex_alu_op;
    logic [2:0]  id_ex_funct3;
    logic        id_ex_funct7b5, id_ex_funct7b0;
    logic [31:0] id_ex_data1, id_ex_data2, id_ex_imm;
    logic [4:0]  id_ex_rd;
    logic [1:0]  forward_a, forward_b;
    logic [31:0] wb_data;
    logic [31:0] alu_out, ex_mem_alu_out, ex_mem_dataB;
    logic        ex_busy, ex_mem_mem_to_reg, ex_mem_reg_write, ex_mem_mem_write, ex_mem_mem_read;
    logic [4:0]  ex_mem_rd;

    int n_chk  = 0;
    int n_pass = 0;

    ex_stage_md #(.XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .id_ex_valid(id_ex_valid),
        .id_ex_mem_to_reg(id_ex_mem_to_reg), .id_ex_reg_write(id_ex_reg_write),
        .id_ex_mem_write(id_ex_mem_write), .id_ex_mem_read(id_ex_mem_read),
        .id_ex_alu_src(id_ex_alu_src), .id_ex_alu_op(id_ex_alu_op),
        .id_ex_funct3(id_ex_funct3), .id_ex_funct7b5(id_ex_funct7b5),
        .id_ex_funct7b0(id_ex_funct7b0), .id_ex_data1(id_ex_data1),
        .id_ex_data2(id_ex_data2), .id_ex_imm(id_ex_imm), .id_ex_rd(id_ex_rd),
        .forward_a(forward_a), .forward_b(forward_b), .wb_data(wb_data),
        .alu_out(alu_out), .ex_busy(ex_busy), .ex_mem_alu_out(ex_mem_alu_out),
        .ex_mem_dataB(ex_mem_dataB), .ex_mem_mem_to_reg(ex_mem_mem_to_reg),
        .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_mem_write(ex_mem_mem_write),
        .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_rd(ex_mem_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [1:0] aop, input logic [2:0] f3, input logic f7b5,
                      input logic f7b0, input logic [31:0] d1, input logic [31:0] d2,
                      input logic [31:0] imm, input logic src);
        id_ex_alu_op   = aop;
        id_ex_funct3   = f3;
        id_ex_funct7b5 = f7b5;
        id_ex_funct7b0 = f7b0;
        id_ex_data1    = d1;
        id_ex_data2    = d2;
        id_ex_imm      = imm;
        id_ex_alu_src  = src;
        #1;
    endtask

    // Runs a held M-op to completion: counts stall cycles, checks the bubble,
    // optionally perturbs wb_data mid-operation, then checks the result.
    task automatic run_md(input string tag, input logic [31:0] exp, input int exp_busy,
                          input int chg_at, input logic [31:0] chg_val);
        int n = 0;
        while (ex_busy && n < 200) begin
            if (n == chg_at) wb_data = chg_val;
            step();
            n++;
            if (n == 1) chk({tag, "_bubble_rw"}, {31'b0, ex_mem_reg_write}, 32'd0);
        end
        chk({tag, "_busy_cycles"}, n, exp_busy);
        chk({tag, "_alu_out"}, alu_out, exp);
        step();
        chk({tag, "_exmem"}, ex_mem_alu_out, exp);
        chk({tag, "_rw"}, {31'b0, ex_mem_reg_write}, 32'd1);
    endtask

    initial begin
        id_ex_valid = 1'b1; id_ex_reg_write = 1'b1; id_ex_mem_to_reg = 1'b0;
        id_ex_mem_write = 1'b0; id_ex_mem_read = 1'b0; id_ex_rd = 5'd9;
        forward_a = 2'b00; forward_b = 2'b00; wb_data = 32'd0;
        op(2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        reset_n = 1'b0;
        step();
        chk("rst_exmem_alu", ex_mem_alu_out, 32'd0);
        chk("rst_exmem_ctl", {27'b0, ex_mem_reg_write, ex_mem_mem_write, ex_mem_mem_read,
                              ex_mem_mem_to_reg, ex_busy}, 32'd0);
        chk("rst_exmem_rd", {27'b0, ex_mem_rd}, 32'd0);
        reset_n = 1'b1;

        // R-type SUB 5 - 7
        op(2'b10, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 32'd0, 1'b0);
        chk("sub_comb", alu_out, 32'hFFFF_FFFE);
        step();
        chk("sub_exmem", ex_mem_alu_out, 32'hFFFF_FFFE);
        chk("sub_rd", {27'b0, ex_mem_rd}, 32'd9);
        chk("sub_dataB", ex_mem_dataB, 32'd7);

        op(2'b11, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd0, 32'd4, 1'b1);
        chk("srai", alu_out, 32'hF800_0000);
        op(2'b10, 3'b011, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        chk("sltu", alu_out, 32'd1);
        op(2'b10, 3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        chk("slt", alu_out, 32'd1);
        // I-type ADD ignores bit 30
        op(2'b11, 3'b000, 1'b1, 1'b0, 32'd3, 32'd0, 32'd10, 1'b1);
        chk("addi_f7", alu_out, 32'd13);
        // shift amount truncated to 5 bits: 33 -> 1
        op(2'b10, 3'b001, 1'b0, 1'b0, 32'd1, 32'd33, 32'd0, 1'b0);
        chk("sll_trunc", alu_out, 32'd2);
        op(2'b10, 3'b101, 1'b1, 1'b0, 32'hF000_0000, 32'd4, 32'd0, 1'b0);
        chk("sra", alu_out, 32'hFF00_0000);
        op(2'b10, 3'b101, 1'b0, 1'b0, 32'hF000_0000, 32'd4, 32'd0, 1'b0);
        chk("srl", alu_out, 32'h0F00_0000);
        op(2'b10, 3'b000, 1'b1, 1'b1 ^ 1'b1, 32'd9, 32'd4, 32'd0, 1'b0);
        op(2'b10, 3'b100, 1'b1, 1'b0, 32'd9, 32'd4, 32'd0, 1'b0);
        chk("undef_code", alu_out, 32'd9);
        step();
        // forward from EX/MEM (9) and wb_data
        forward_a = 2'b10; forward_b = 2'b01; wb_data = 32'd100;
        op(2'b01, 3'b000, 1'b0, 1'b0, 32'd55, 32'd66, 32'd0, 1'b0);
        chk("fwd_sub", alu_out, 32'hFFFF_FFA5);
        forward_a = 2'b11; forward_b = 2'b00;
        op(2'b00, 3'b000, 1'b0, 1'b0, 32'd55, 32'd66, 32'd0, 1'b0);
        chk("fwd11_add", alu_out, 32'd121);
        step();

        // invalid M-op: no stall, EX/MEM loads controls as-is
        id_ex_valid = 1'b0;
        op(2'b10, 3'b000, 1'b0, 1'b1, 32'd3, 32'd5, 32'd0, 1'b0);
        chk("inv_busy", {31'b0, ex_busy}, 32'd0);
        step();
        chk("inv_rw", {31'b0, ex_mem_reg_write}, 32'd1);
        id_ex_valid = 1'b1;

`ifdef M_EXT_EN
        op(2'b10, 3'b000, 1'b0, 1'b1, 32'h1234_5678, 32'h10, 32'd0, 1'b0);
        run_md("mul", 32'h2345_6780, 33, -1, 32'd0);
        op(2'b10, 3'b100, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0);
        run_md("div", 32'hFFFF_FFFD, 33, -1, 32'd0);
        op(2'b10, 3'b110, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0);
        run_md("rem", 32'hFFFF_FFFF, 33, -1, 32'd0);
        op(2'b10, 3'b101, 1'b0, 1'b1, 32'd100, 32'd7, 32'd0, 1'b0);
        run_md("divu", 32'd14, 33, -1, 32'd0);
        op(2'b10, 3'b111, 1'b0, 1'b1, 32'd100, 32'd7, 32'd0, 1'b0);
        run_md("remu", 32'd2, 33, -1, 32'd0);
        op(2'b10, 3'b101, 1'b0, 1'b1, 32'd7, 32'd0, 32'd0, 1'b0);
        run_md("divu0", 32'hFFFF_FFFF, 1, -1, 32'd0);
        op(2'b10, 3'b111, 1'b0, 1'b1, 32'd7, 32'd0, 32'd0, 1'b0);
        run_md("remu0", 32'd7, 1, -1, 32'd0);
        op(2'b10, 3'b100, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_md("div_ovf", 32'h8000_0000, 1, -1, 32'd0);
        op(2'b10, 3'b110, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_md("rem_ovf", 32'd0, 1, -1, 32'd0);
        op(2'b10, 3'b001, 1'b0, 1'b1, 32'd3, 32'd5, 32'd0, 1'b0);
        chk("mulh_zero", alu_out, 32'd0);
        chk("mulh_busy", {31'b0, ex_busy}, 32'd0);
        forward_a = 2'b01; wb_data = 32'd3;
        op(2'b10, 3'b000, 1'b0, 1'b1, 32'd99, 32'd5, 32'd0, 1'b0);
        run_md("mul_fwd", 32'd15, 33, 5, 32'd100);
        forward_a = 2'b00;
`else
        op(2'b10, 3'b000, 1'b0, 1'b1, 32'h1234_5678, 32'h10, 32'd0, 1'b0);
        chk("nom_mul", alu_out, 32'h1234_5678);
        chk("nom_busy", {31'b0, ex_busy}, 32'd0);
        op(2'b10, 3'b001, 1'b0, 1'b1, 32'd3, 32'd5, 32'd0, 1'b0);
        chk("nom_mulh", alu_out, 32'd3);
        step();
        chk("nom_exmem", ex_mem_alu_out, 32'd3);
`endif

        // reset in the middle of a (potential) multiply
        op(2'b10, 3'b000, 1'b0, 1'b1, 32'd6, 32'd7, 32'd0, 1'b0);
        for (int i = 0; i < 11; i++) step();
        reset_n = 1'b0;
        #1;
        chk("rst_mid_busy", {31'b0, ex_busy}, 32'd0);
        chk("rst_mid_alu", ex_mem_alu_out, 32'd0);
        chk("rst_mid_ctl", {26'b0, ex_mem_rd, ex_mem_reg_write}, 32'd0);
        op(2'b00, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 1'b0);
        reset_n = 1'b1;
        step();
        chk("post_rst_add", ex_mem_alu_out, 32'd3);
        chk("post_rst_rw", {31'b0, ex_mem_reg_write}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ex_stage_md.md
Name: ex_stage_md

Overview:
Parametrised execute stage with EX/MEM pipeline register. Extends the single-cycle ALU with the full RV32I operation set and an iterative multiply/divide unit. The multiply/divide unit runs multi-cycle and stalls the front of the pipeline through ex_busy. Sits between the ID/EX register and the MEM stage and keeps the same 2-bit forwarding-select scheme.

Parameters:
XLEN, 32, datapath width; power of two, >= 8
SHW, $clog2(XLEN), shift-amount width (derived, do not override)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous reset, active-low
id_ex_valid  in  1  ID/EX holds a real instruction
id_ex_mem_to_reg, id_ex_reg_write, id_ex_mem_write, id_ex_mem_read  in  1 each  control from ID/EX
id_ex_alu_src  in  1  1 = immediate is ALU input B
id_ex_alu_op  in  2  00 = ADD, 01 = SUB (branch), 10 = R-type, 11 = I-type ALU
id_ex_funct3  in  3  instruction funct3
id_ex_funct7b5  in  1  instruction bit 30
id_ex_funct7b0  in  1  instruction bit 25 (M-extension select)
id_ex_data1, id_ex_data2, id_ex_imm  in  XLEN each  operands
id_ex_rd  in  5  destination register
forward_a, forward_b  in  2 each  00 = ID/EX, 01 = wb_data, 10 = ex_mem_alu_out, 11 = ID/EX
wb_data  in  XLEN  writeback forwarding source
alu_out  out  XLEN  combinational result
ex_busy  out  1  combinational; 1 = hold IF/ID/ID-EX and PC
ex_mem_alu_out, ex_mem_dataB  out  XLEN each  registered
ex_mem_mem_to_reg, ex_mem_reg_write, ex_mem_mem_write, ex_mem_mem_read  out  1 each  registered
ex_mem_rd  out  5  registered

Behaviour:
- Reset is asynchronous and active-low. All ex_mem_* outputs reset to 0, the FSM resets to IDLE, and ex_busy is 0.
- Operand A is dataA, the forward_a-selected value. dataB is the forward_b-selected value. Operand B is id_ex_imm when alu_src = 1, otherwise dataB.
- Decode for alu_op 10 with funct7b0 = 0 uses {funct7b5, funct3}:
  - 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU
  - 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND
  - any other code: alu_out = dataA
- Decode for alu_op 11 is the same, except funct7b5 is honoured only for funct3 = 101 and forced to 0 otherwise.
- Shifts use only operand B[SHW-1:0].
- SLT and SLTU return 1 or 0, zero-extended to XLEN.
- Multiply/divide op: alu_op = 10 and funct7b0 = 1. funct3 000 MUL (low XLEN bits of product), 100 DIV, 101 DIVU, 110 REM, 111 REMU. funct3 001/010/011 give alu_out = 0 in a single cycle with no stall.
- FSM states: IDLE, CALC, DONE.
  - IDLE: on a valid multiply/divide op, latch operands (forwarded values), load count = XLEN-1, go to CALC, ex_busy = 1.
  - IDLE special cases go straight to DONE with ex_busy = 1 for one cycle:
    - divisor 0: quotient = all ones, remainder = dividend.
    - signed most-negative / -1: quotient = dividend, remainder = 0.
  - CALC: one bit per cycle. MUL uses shift-add. Division is restoring and operates on magnitudes; the result sign is fixed in DONE. Count decrements each cycle; at 0, go to DONE. ex_busy = 1.
  - DONE: ex_busy = 0 and alu_out = result; the EX/MEM register captures it this edge. Next state is IDLE. The same held instruction is not re-started.
- Latency: normal multiply/divide stalls XLEN+1 cycles (33 at XLEN = 32), with the result in EX/MEM at the end of cycle XLEN+2. A special case stalls 1 cycle. Other ops take 1 cycle.
- While ex_busy = 1, EX/MEM loads a bubble: reg_write, mem_write, mem_read, mem_to_reg = 0 and rd = 0. ex_mem_alu_out and ex_mem_dataB hold their values.
- Upstream holds ID/EX stable and leaves forward_* unchanged while ex_busy = 1. Latched operands make the result immune to forwarding changes.
- id_ex_valid = 0 never starts the FSM; EX/MEM loads inputs as-is.
- Reset mid-operation aborts the op: FSM to IDLE, no result written.

Optional Feature:
M_EXT_EN. Defined: multiply/divide unit, FSM and ex_busy behave as above. Undefined: no FSM is built and ex_busy is tied to 0. An alu_op 10 instruction with funct7b0 = 1 gives alu_out = dataA, single cycle.

Test Plan:
- R-type SUB with data1 = 5, data2 = 7, forward 00 -> alu_out = 0xFFFFFFFE; one edge later ex_mem_alu_out = 0xFFFFFFFE and ex_mem_rd = id_ex_rd.
- SRA with data1 = 0x80000000, imm = 4, alu_op 11, funct7b5 = 1 -> 0xF8000000. SLTU with 1 vs 0xFFFFFFFF -> 1.
- MUL 0x12345678 * 0x10 -> ex_busy high 33 cycles with EX/MEM bubble (reg_write = 0); then ex_mem_alu_out = 0x23456780 and reg_write = 1.
- DIV -7 / 2 -> quotient 0xFFFFFFFD. REM -7 / 2 -> 0xFFFFFFFF. DIVU 7 / 0 -> 0xFFFFFFFF with ex_busy exactly 1 cycle.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 with a 1-cycle stall. Start MUL with forward_a = 01, then change wb_data mid-CALC -> result uses the latched value.
- Assert reset_n low in CALC cycle 10 -> ex_busy = 0 and all ex_mem_* = 0 immediately; after release, ADD 1 + 2 -> ex_mem_alu_out = 3.
